// File: rtl/snd_sample_fifo_pkg.sv
// Shared constants for the BGM sample path: packed stereo word layout and the silence word.
package snd_pkg;
  localparam int unsigned SND_WORD_W = 32;
  localparam int unsigned SND_CH_W   = 16;
  localparam int unsigned SND_L_LSB  = 0;
  localparam int unsigned SND_R_LSB  = 16;
  localparam logic [SND_WORD_W-1:0] SND_SILENCE = 32'h0000_0000;
endpackage

// File: rtl/snd_sample_fifo_if.sv
// Loader/snd_buffer side bundle of snd_sample_fifo.
// Optional macro SND_FIFO_STATS_EN adds UNDERRUN_CNT.
interface snd_sample_fifo_if
  import snd_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 9
);
  logic                  M_BGM_PLAY;
  logic                  WR_EN;
  logic [SND_WORD_W-1:0] WR_DATA;
  logic                  WR_FULL;
  logic                  FIFO_RD;
  logic                  FIFO_VALID;
  logic [SND_WORD_W-1:0] FIFO_DOUT;
  logic [DEPTH_LOG2:0]   FIFO_LEVEL;
  logic                  FILL_REQ;
  logic                  UNDERRUN;
`ifdef SND_FIFO_STATS_EN
  logic [15:0]           UNDERRUN_CNT;
`endif

  modport master (
    output M_BGM_PLAY, WR_EN, WR_DATA, FIFO_RD,
    input  WR_FULL, FIFO_VALID, FIFO_DOUT, FIFO_LEVEL, FILL_REQ, UNDERRUN
`ifdef SND_FIFO_STATS_EN
    , input UNDERRUN_CNT
`endif
  );

  modport slave (
    input  M_BGM_PLAY, WR_EN, WR_DATA, FIFO_RD,
    output WR_FULL, FIFO_VALID, FIFO_DOUT, FIFO_LEVEL, FILL_REQ, UNDERRUN
`ifdef SND_FIFO_STATS_EN
    , output UNDERRUN_CNT
`endif
  );
endinterface

// File: rtl/snd_sample_fifo_ram.sv
// Simple dual-port sample store with a registered read port; contents are not reset.
module snd_fifo_ram #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;
endmodule

// File: rtl/snd_sample_fifo.sv
// BGM sample FIFO: pointers, flags, level, underrun silence and refill request.
// Optional macro SND_FIFO_STATS_EN adds a saturating underrun counter.
module snd_sample_fifo
  import snd_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 9,
  parameter int unsigned AEMPTY_TH  = 128
) (
  input  logic               SND_MCLK,
  input  logic               SND_RSTN,
  snd_sample_fifo_if.slave   bus
);
  localparam int unsigned PW = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] LP_TH = PW'(AEMPTY_TH);

  logic [PW-1:0]         r_wr_ptr, r_rd_ptr, r_level;
  logic [PW-1:0]         w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic                  w_empty, w_full, w_wr_acc, w_rd_req, w_rd_acc;
  logic                  r_valid, r_underrun, r_fill, r_silence;
  logic [SND_WORD_W-1:0] w_ram_q;

  always_comb begin
    w_empty      = (r_wr_ptr == r_rd_ptr);
    w_full       = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                   (r_wr_ptr[PW-2:0] == r_rd_ptr[PW-2:0]);
    w_wr_acc     = bus.WR_EN && bus.M_BGM_PLAY && !w_full;
    w_rd_req     = bus.FIFO_RD && bus.M_BGM_PLAY;
    w_rd_acc     = w_rd_req && !w_empty;
    w_wr_ptr_nxt = r_wr_ptr + PW'(w_wr_acc);
    w_rd_ptr_nxt = r_rd_ptr + PW'(w_rd_acc);
  end

  snd_fifo_ram #(.AW(DEPTH_LOG2), .DW(SND_WORD_W)) u_ram (
    .clk     (SND_MCLK),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr[PW-2:0]),
    .i_wdata (bus.WR_DATA),
    .i_re    (w_rd_acc),
    .i_raddr (r_rd_ptr[PW-2:0]),
    .o_rdata (w_ram_q)
  );

  // r_silence selects the silence word instead of the un-reset RAM register;
  // it only changes on a read, so FIFO_DOUT holds between pulses.
  always_ff @(posedge SND_MCLK or negedge SND_RSTN) begin
    if (!SND_RSTN) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_valid    <= 1'b0;
      r_underrun <= 1'b0;
      r_fill     <= 1'b0;
      r_silence  <= 1'b1;
    end else begin
      r_valid    <= w_rd_req;
      r_underrun <= w_rd_req && w_empty;
      r_fill     <= bus.M_BGM_PLAY && (r_level < LP_TH);
      if (w_rd_req) r_silence <= w_empty;
      if (!bus.M_BGM_PLAY) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        r_wr_ptr <= w_wr_ptr_nxt;
        r_rd_ptr <= w_rd_ptr_nxt;
        r_level  <= w_wr_ptr_nxt - w_rd_ptr_nxt;
      end
    end
  end

  assign bus.WR_FULL    = w_full;
  assign bus.FIFO_VALID = r_valid;
  assign bus.FIFO_DOUT  = r_silence ? SND_SILENCE : w_ram_q;
  assign bus.FIFO_LEVEL = r_level;
  assign bus.FILL_REQ   = r_fill;
  assign bus.UNDERRUN   = r_underrun;

`ifdef SND_FIFO_STATS_EN
  logic        r_play_d;
  logic [15:0] r_und_cnt;

  always_ff @(posedge SND_MCLK or negedge SND_RSTN) begin
    if (!SND_RSTN) begin
      r_play_d  <= 1'b0;
      r_und_cnt <= '0;
    end else begin
      r_play_d <= bus.M_BGM_PLAY;
      if (bus.M_BGM_PLAY && !r_play_d) r_und_cnt <= '0;
      else if (r_underrun && (r_und_cnt != '1)) r_und_cnt <= r_und_cnt + 16'd1;
    end
  end

  assign bus.UNDERRUN_CNT = r_und_cnt;
`else
  // Statistics disabled: no counter state exists in this build.
`endif
endmodule
